// File: rtl/clk_div_multi.sv
// Multi-output fabric clock divider: NUM_CLOCKS counter-based divided clocks
// with per-channel divide ratio and phase, one-cycle enable strobes, a
// run-time config handshake and a lock flag that covers every realignment.
module clk_div_multi #(
  parameter int NUM_CLOCKS  = 2,
  parameter int DIV_W       = 8,
  parameter int DEF_DIV     = 2,
  parameter int LOCK_CYCLES = 16,
  parameter int CH_W        = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] clk_en,
  output logic                  locked
);

  // One spare bit so the all-ones reset value never matches the last count;
  // incrementing it wraps to zero, which makes the release edge the first
  // counted SETTLE cycle, exactly like a config accept edge.
  localparam int LCW = $clog2(LOCK_CYCLES) + 1;
  localparam logic [DIV_W-1:0] DEF_DIV_EFF = (DEF_DIV == 0) ? DIV_W'(1) : DIV_W'(DEF_DIV);

  typedef enum logic {SETTLE = 1'b0, RUN = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [LCW-1:0]          lock_cnt_q, lock_cnt_d;
  logic [DIV_W-1:0]        div_q [NUM_CLOCKS];
  logic [DIV_W-1:0]        div_d [NUM_CLOCKS];
  logic [DIV_W-1:0]        ph_q  [NUM_CLOCKS];
  logic [DIV_W-1:0]        ph_d  [NUM_CLOCKS];
  logic [DIV_W-1:0]        cnt_q [NUM_CLOCKS];
  logic [DIV_W-1:0]        cnt_d [NUM_CLOCKS];
  logic [NUM_CLOCKS-1:0]   outclk_q, outclk_d;
  logic [NUM_CLOCKS-1:0]   clk_en_q, clk_en_d;
  logic                    locked_q, locked_d;
  logic                    accept_s;
  logic                    ch_ok_s;
  logic [DIV_W-1:0]        new_div_s;
  logic [DIV_W-1:0]        new_ph_s;

  // A divide ratio of zero behaves as divide-by-one.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    if (d == '0) eff_div = DIV_W'(1);
    else         eff_div = d;
  endfunction

  // Phases at or beyond the ratio saturate to the last position.
  function automatic logic [DIV_W-1:0] eff_phase(input logic [DIV_W-1:0] p,
                                                 input logic [DIV_W-1:0] d);
    if (p >= d) eff_phase = d - DIV_W'(1);
    else        eff_phase = p;
  endfunction

  // (div - ph) mod div without a divider, valid because ph < div.
  function automatic logic [DIV_W-1:0] align_load(input logic [DIV_W-1:0] d,
                                                  input logic [DIV_W-1:0] p);
    if (p == '0) align_load = '0;
    else         align_load = d - p;
  endfunction

  assign accept_s  = cfg_valid & locked_q;
  assign ch_ok_s   = (int'(cfg_ch) < NUM_CLOCKS);
  assign new_div_s = eff_div(cfg_div);
  assign new_ph_s  = eff_phase(cfg_phase, new_div_s);

  // Next-state logic: lock sequencing, config capture, channel counters and
  // the values the output flops will take.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    outclk_d   = '0;
    clk_en_d   = '0;
    locked_d   = 1'b0;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      div_d[i] = div_q[i];
      ph_d[i]  = ph_q[i];
      cnt_d[i] = cnt_q[i];
    end
    case (state_q)
      SETTLE: begin
        if (lock_cnt_q == LCW'(LOCK_CYCLES - 1)) begin
          state_d = RUN;
          for (int i = 0; i < NUM_CLOCKS; i++) begin
            cnt_d[i] = align_load(div_q[i], ph_q[i]);
          end
        end else begin
          lock_cnt_d = lock_cnt_q + LCW'(1);
        end
      end
      RUN: begin
        if (accept_s && ch_ok_s) begin
          state_d    = SETTLE;
          lock_cnt_d = '0;
          for (int i = 0; i < NUM_CLOCKS; i++) begin
            if (int'(cfg_ch) == i) begin
              div_d[i] = new_div_s;
              ph_d[i]  = new_ph_s;
            end else begin
              div_d[i] = div_q[i];
              ph_d[i]  = ph_q[i];
            end
          end
        end else begin
          for (int i = 0; i < NUM_CLOCKS; i++) begin
            if (cnt_q[i] >= div_q[i] - DIV_W'(1)) cnt_d[i] = '0;
            else                                   cnt_d[i] = cnt_q[i] + DIV_W'(1);
          end
        end
      end
      default: begin
        state_d    = SETTLE;
        lock_cnt_d = '0;
      end
    endcase
    if (state_d == RUN) begin
      locked_d = 1'b1;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        outclk_d[i] = (div_d[i] == DIV_W'(1)) || (cnt_d[i] < (div_d[i] >> 1));
        clk_en_d[i] = (cnt_d[i] == '0);
      end
    end else begin
      locked_d = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge refclk) begin
    if (!rst) begin
      state_q    <= SETTLE;
      lock_cnt_q <= '1;
      outclk_q   <= '0;
      clk_en_q   <= '0;
      locked_q   <= 1'b0;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        div_q[i] <= DEF_DIV_EFF;
        ph_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      outclk_q   <= outclk_d;
      clk_en_q   <= clk_en_d;
      locked_q   <= locked_d;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        div_q[i] <= div_d[i];
        ph_q[i]  <= ph_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign outclk    = outclk_q;
  assign clk_en    = clk_en_q;
  assign locked    = locked_q;
  assign cfg_ready = locked_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: a cycle-level model derived from the divide/phase
// rules is compared against the DUT every cycle, plus directed literal checks.
module tb_clk_div_multi;
  localparam int NC   = 2;
  localparam int LOCK = 16;
  localparam int DEFD = 2;

  logic          refclk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_ch;
  logic [7:0]    cfg_div;
  logic [7:0]    cfg_phase;
  logic [NC-1:0] outclk;
  logic [NC-1:0] clk_en;
  logic          locked;

  int vectors = 0;
  int miscompares = 0;

  clk_div_multi #(.NUM_CLOCKS(NC), .DIV_W(8), .DEF_DIV(DEFD),
                  .LOCK_CYCLES(LOCK), .CH_W(2)) dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .outclk(outclk), .clk_en(clk_en), .locked(locked));

  always #5 refclk = ~refclk;

  // Model: each channel's waveform is a function of the cycles elapsed since
  // the last alignment point, its ratio and its phase.
  int            e = 0;
  bit            m_init = 1'b0;
  bit            m_locked = 1'b0;
  int            run_edge = 0;
  int            mdiv [NC];
  int            mph  [NC];
  logic [NC-1:0] exp_out = '0;
  logic [NC-1:0] exp_en = '0;

  always @(posedge refclk) begin
    int d, t, m;
    e = e + 1;
    if (!rst) begin
      m_init   = 1'b1;
      m_locked = 1'b0;
      run_edge = e + 1 + LOCK;
      for (int i = 0; i < NC; i++) begin mdiv[i] = DEFD; mph[i] = 0; end
    end else if (m_init) begin
      if (cfg_valid && m_locked && int'(cfg_ch) < NC) begin
        d = (cfg_div == 8'd0) ? 1 : int'(cfg_div);
        mdiv[cfg_ch] = d;
        mph[cfg_ch]  = (int'(cfg_phase) >= d) ? d - 1 : int'(cfg_phase);
        run_edge = e + LOCK;
      end
      m_locked = (e >= run_edge);
    end
    exp_out = '0;
    exp_en  = '0;
    if (m_locked) begin
      t = e - run_edge;
      for (int i = 0; i < NC; i++) begin
        m = (((t - mph[i]) % mdiv[i]) + mdiv[i]) % mdiv[i];
        exp_out[i] = (mdiv[i] == 1) || (m < mdiv[i] / 2);
        exp_en[i]  = (m == 0);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge refclk) begin
    if (m_init) begin
      vectors++;
      if ({outclk, clk_en, locked, cfg_ready} !== {exp_out, exp_en, m_locked, m_locked}) begin
        miscompares++;
        $display("FAIL cycle %0d: outclk/clk_en/locked/ready got %b/%b/%b/%b want %b/%b/%b/%b",
                 e, outclk, clk_en, locked, cfg_ready, exp_out, exp_en, m_locked, m_locked);
      end
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  // Present a request at a negedge and hold it until accepted; returns the
  // number of cycles spent waiting for cfg_ready.
  task automatic do_cfg(input logic [1:0] ch, input logic [7:0] dv,
                        input logic [7:0] ph, output int waited);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_div = dv; cfg_phase = ph;
    waited = 0;
    while (cfg_ready !== 1'b1 && waited < 200) begin
      @(negedge refclk);
      waited++;
    end
    if (waited >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL cfg_timeout: got no cfg_ready want cfg_ready within 200 cycles");
    end
    @(negedge refclk);
    cfg_valid = 1'b0;
  endtask

  initial begin
    int w;
    rst = 1'b0; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0; cfg_phase = 8'd0;
    tick(3);
    chk("reset_outputs", int'({outclk, clk_en, locked, cfg_ready}), 0);
    rst = 1'b1;

    // Lock after reset release
    tick(16);
    chk("lock_c16", int'(locked), 0);
    tick(1);
    chk("lock_c17", int'(locked), 1);
    chk("first_run", int'({outclk, clk_en}), 4'b1111);
    chk("model_first_run", int'({exp_out, exp_en}), 4'b1111);
    tick(1);
    chk("second_run", int'({outclk, clk_en}), 4'b0000);
    tick(6);

    // Channel 1 to div 5, phase 2
    do_cfg(2'd1, 8'd5, 8'd2, w);
    chk("reprog_drop", int'(locked), 0);
    tick(15);
    chk("reprog_c16", int'(locked), 0);
    tick(1);
    chk("reprog_t0", int'({outclk, clk_en}), 4'b0101);
    chk("model_reprog_t0", int'({exp_out, exp_en}), 4'b0101);
    tick(2);
    chk("reprog_t2", int'({outclk, clk_en}), 4'b1111);
    tick(1);
    chk("reprog_t3_high", int'(outclk[1]), 1);
    tick(1);
    chk("reprog_t4_low", int'(outclk[1]), 0);
    tick(5);
    chk("reprog_t9_low", int'(outclk[1]), 0);
    tick(3);
    chk("reprog_t12_en", int'(clk_en[1]), 1);
    tick(4);

    // Divide by zero and one
    do_cfg(2'd0, 8'd0, 8'd0, w);
    tick(16);
    chk("div0_out", int'({outclk[0], clk_en[0]}), 2'b11);
    tick(1);
    chk("div0_out2", int'({outclk[0], clk_en[0]}), 2'b11);
    do_cfg(2'd1, 8'd1, 8'd3, w);
    tick(16);
    chk("div1_all", int'({outclk, clk_en}), 4'b1111);
    tick(3);
    chk("div1_all2", int'({outclk, clk_en}), 4'b1111);

    // Phase beyond ratio saturates: div 4, phase 9 acts as phase 3
    do_cfg(2'd1, 8'd4, 8'd9, w);
    tick(16);
    chk("ph_sat_t0", int'({outclk[1], clk_en[1]}), 2'b10);
    tick(3);
    chk("ph_sat_t3", int'(clk_en[1]), 1);
    chk("model_ph_sat_t3", int'(exp_en[1]), 1);
    tick(6);

    // Out-of-range channel: dropped, lock kept
    do_cfg(2'd3, 8'd7, 8'd7, w);
    chk("oor_wait", w, 0);
    chk("oor_locked", int'(locked), 1);
    tick(8);

    // Request held across SETTLE
    do_cfg(2'd1, 8'd2, 8'd0, w);
    do_cfg(2'd0, 8'd3, 8'd1, w);
    chk("held_wait", w, 16);
    chk("held_locked", int'(locked), 0);
    tick(16);
    chk("held_relock", int'(locked), 1);
    tick(10);

    // Reset mid-SETTLE after a reprogram
    do_cfg(2'd1, 8'd5, 8'd2, w);
    tick(5);
    rst = 1'b0;
    tick(2);
    chk("rst_mid_outputs", int'({outclk, clk_en, locked, cfg_ready}), 0);
    rst = 1'b1;
    tick(16);
    chk("rst_mid_c16", int'(locked), 0);
    tick(1);
    chk("rst_mid_c17", int'(locked), 1);
    chk("rst_mid_default", int'({outclk, clk_en}), 4'b1111);
    tick(1);
    chk("rst_mid_default2", int'({outclk, clk_en}), 4'b0000);
    tick(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
